// File: rtl/slave_port_pkg.sv
// Shared state encoding, transfer-mode constants and sizing helper for the bit-serial slave port.
package slave_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_PARITY,
    ST_WRITE,
    ST_READ,
    ST_RDATA
  } state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Serial bus between a bus master and one slave_port instance.
interface slave_port_if;

  logic mvalid;
  logic smode;
  logic swdata;
  logic sready;
  logic srdata;
  logic svalid;
  logic perr;

  modport master (
    output mvalid, smode, swdata,
    input  sready, srdata, svalid, perr
  );

  modport slave (
    input  mvalid, smode, swdata,
    output sready, srdata, svalid, perr
  );

endinterface

// File: rtl/slave_port_shifter.sv
// Right-shifting register: serial-in at the MSB (LSB-first stream), parallel load and parallel out.
module slave_port_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_i,
  input  logic             ser_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Load wins over shift; LSB-first streams end up with bit0 at position 0.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = par_i;
    end else if (shift_i) begin
      q_d = {ser_i, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign par_o = q_q;

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave front-end: deserialises address/write data, strobes the memory, serialises read data.
// Optional even-parity check bit enabled by defining SLAVE_PORT_PARITY_EN.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  slave_port_if.slave           bus,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH)) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
`ifdef SLAVE_PORT_PARITY_EN
  logic             par_q;
  logic             perr_q;
`endif

  logic                  addr_shift;
  logic                  wdata_shift;
  logic                  rd_load;
  logic                  rd_shift;
  logic [DATA_WIDTH-1:0] rd_q;

  // The first address bit is already taken in IDLE, so the address shifter also runs there.
  always_comb begin
    addr_shift  = bus.mvalid && ((state_q == ST_IDLE) || (state_q == ST_ADDR));
    wdata_shift = bus.mvalid && (state_q == ST_WDATA);
    rd_load     = (state_q == ST_READ);
    rd_shift    = (state_q == ST_RDATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_READ;
`ifdef SLAVE_PORT_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
`ifdef SLAVE_PORT_PARITY_EN
      perr_q <= 1'b0;
      if (addr_shift || wdata_shift) begin
        par_q <= (state_q == ST_IDLE) ? bus.swdata : (par_q ^ bus.swdata);
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.mvalid) begin
            mode_q  <= bus.smode;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (!bus.mvalid) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == ADDR_LAST) begin
            cnt_q <= '0;
            if (mode_q == MODE_WRITE) begin
              state_q <= ST_WDATA;
            end else begin
`ifdef SLAVE_PORT_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_READ;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          if (!bus.mvalid) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == DATA_LAST) begin
            cnt_q <= '0;
`ifdef SLAVE_PORT_PARITY_EN
            state_q <= ST_PARITY;
`else
            state_q <= ST_WRITE;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef SLAVE_PORT_PARITY_EN
        ST_PARITY: begin
          if (!bus.mvalid) begin
            state_q <= ST_IDLE;
          end else if (bus.swdata == par_q) begin
            state_q <= (mode_q == MODE_WRITE) ? ST_WRITE : ST_READ;
          end else begin
            perr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
`endif
        ST_WRITE: begin
          state_q <= ST_IDLE;
        end
        ST_READ: begin
          cnt_q   <= '0;
          state_q <= ST_RDATA;
        end
        ST_RDATA: begin
          if (cnt_q == DATA_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  slave_port_shifter #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .shift_i (addr_shift),
    .ser_i   (bus.swdata),
    .load_i  (1'b0),
    .par_i   ('0),
    .par_o   (mem_addr)
  );

  slave_port_shifter #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk     (clk),
    .rst     (rst),
    .shift_i (wdata_shift),
    .ser_i   (bus.swdata),
    .load_i  (1'b0),
    .par_i   ('0),
    .par_o   (mem_wdata)
  );

  // Zeros shift in behind the read data so srdata settles back to 0.
  slave_port_shifter #(.WIDTH(DATA_WIDTH)) u_rdata (
    .clk     (clk),
    .rst     (rst),
    .shift_i (rd_shift),
    .ser_i   (1'b0),
    .load_i  (rd_load),
    .par_i   (mem_rdata),
    .par_o   (rd_q)
  );

  assign mem_wen    = (state_q == ST_WRITE);
  assign mem_ren    = (state_q == ST_READ);
  assign bus.sready = (state_q == ST_IDLE);
  assign bus.svalid = (state_q == ST_RDATA);
  assign bus.srdata = rd_q[0];
`ifdef SLAVE_PORT_PARITY_EN
  assign bus.perr   = perr_q;
`else
  assign bus.perr   = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port.sv
// Directed self-checking bench for slave_port (ADDR_WIDTH=12, DATA_WIDTH=8) in front of a small memory model.
module tb_slave_port;

  logic        clk;
  logic        rst;
  logic        memWen;
  logic        memRen;
  logic [11:0] memAddr;
  logic [7:0]  memWdata;
  logic [7:0]  memRdata;
  logic [7:0]  mem [0:4095];

  int checks;
  int errors;
  int wenCount;
  int renCount;
  int perrCount;

  slave_port_if bus ();

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_wen   (memWen),
    .mem_ren   (memRen),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdata (memRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory: registered write, combinational read.
  always @(posedge clk) begin
    if (memWen) mem[memAddr] <= memWdata;
  end
  assign memRdata = mem[memAddr];

  // Strobe and error pulses are tallied mid-cycle so every high cycle is counted once.
  always @(negedge clk) begin
    if (memWen) wenCount <= wenCount + 1;
    if (memRen) renCount <= renCount + 1;
    if (bus.perr) perrCount <= perrCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction bit by bit and returns one cycle after the last serial bit.
  task automatic applyStimulus(input logic isWrite, input logic [11:0] addr, input logic [7:0] data,
                               input logic badParity);
    bus.mvalid = 1'b1;
    bus.smode  = isWrite;
    for (int i = 0; i < 12; i++) begin
      bus.swdata = addr[i];
      stepCycle();
    end
    if (isWrite) begin
      for (int i = 0; i < 8; i++) begin
        bus.swdata = data[i];
        stepCycle();
      end
    end
`ifdef SLAVE_PORT_PARITY_EN
    bus.swdata = (^addr) ^ (isWrite ? (^data) : 1'b0) ^ badParity;
    stepCycle();
`else
    if (badParity) $display("[TB] parity flip ignored without parity build");
`endif
    bus.mvalid = 1'b0;
    bus.smode  = 1'b0;
    bus.swdata = 1'b0;
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [7:0] data);
    int wenBefore;
    wenBefore = wenCount;
    applyStimulus(1'b1, addr, data, 1'b0);
    checkOutput($sformatf("wen@%0h", addr), memWen, 1'b1);
    checkOutput($sformatf("waddr@%0h", addr), memAddr, addr);
    checkOutput($sformatf("wdata@%0h", addr), memWdata, data);
    stepCycle();
    checkOutput($sformatf("wenPulses@%0h", addr), wenCount - wenBefore, 1);
    checkOutput($sformatf("wenLow@%0h", addr), memWen, 1'b0);
    checkOutput($sformatf("readyAfterWrite@%0h", addr), bus.sready, 1'b1);
  endtask

  task automatic doRead(input logic [11:0] addr, input logic [7:0] expected);
    int renBefore;
    renBefore = renCount;
    applyStimulus(1'b0, addr, 8'h00, 1'b0);
    checkOutput($sformatf("ren@%0h", addr), memRen, 1'b1);
    checkOutput($sformatf("wenDuringRead@%0h", addr), memWen, 1'b0);
    stepCycle();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("svalid@%0h[%0d]", addr, i), bus.svalid, 1'b1);
      checkOutput($sformatf("srdata@%0h[%0d]", addr, i), bus.srdata, expected[i]);
      stepCycle();
    end
    checkOutput($sformatf("renPulses@%0h", addr), renCount - renBefore, 1);
    checkOutput($sformatf("svalidEnd@%0h", addr), bus.svalid, 1'b0);
    checkOutput($sformatf("readyAfterRead@%0h", addr), bus.sready, 1'b1);
  endtask

  initial begin
    int wenBefore;
    int renBefore;
    logic [7:0] pattern;
    checks = 0;
    errors = 0;
    wenCount = 0;
    renCount = 0;
    perrCount = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    bus.mvalid = 1'b0;
    bus.smode  = 1'b0;
    bus.swdata = 1'b0;
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;

    checkOutput("rstReady", bus.sready, 1'b1);
    checkOutput("rstSvalid", bus.svalid, 1'b0);
    checkOutput("rstSrdata", bus.srdata, 1'b0);
    checkOutput("rstPerr", bus.perr, 1'b0);
    checkOutput("rstWen", memWen, 1'b0);
    checkOutput("rstRen", memRen, 1'b0);
    checkOutput("rstAddr", memAddr, 12'h000);
    checkOutput("rstWdata", memWdata, 8'h00);

    // 0x3C LSB first is 0,0,1,1,1,1,0,0.
    doWrite(12'h0A5, 8'h3C);
    doRead(12'h0A5, 8'h3C);

    // Back-to-back: the read starts in the first idle cycle after the write.
    doWrite(12'hFFF, 8'hFF);
    doRead(12'hFFF, 8'hFF);

    // Abort after five address bits.
    wenBefore = wenCount;
    renBefore = renCount;
    bus.mvalid = 1'b1;
    bus.smode  = 1'b1;
    pattern = 8'b0001_0110;
    for (int i = 0; i < 5; i++) begin
      bus.swdata = pattern[i];
      stepCycle();
    end
    checkOutput("abortBusy", bus.sready, 1'b0);
    bus.mvalid = 1'b0;
    bus.smode  = 1'b0;
    bus.swdata = 1'b0;
    stepCycle();
    checkOutput("abortReady", bus.sready, 1'b1);
    for (int i = 0; i < 25; i++) stepCycle();
    checkOutput("abortNoWen", wenCount - wenBefore, 0);
    checkOutput("abortNoRen", renCount - renBefore, 0);
    doWrite(12'h123, 8'h5A);
    doRead(12'h123, 8'h5A);

    // Reset while the fourth read bit is on the wire.
    wenBefore = wenCount;
    applyStimulus(1'b0, 12'h0A5, 8'h00, 1'b0);
    stepCycle();
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("preRstBit3", bus.srdata, 1'b1);
    rst = 1'b1;
    stepCycle();
    checkOutput("midRstSvalid", bus.svalid, 1'b0);
    checkOutput("midRstReady", bus.sready, 1'b1);
    checkOutput("midRstSrdata", bus.srdata, 1'b0);
    rst = 1'b0;
    stepCycle();
    checkOutput("midRstNoWen", wenCount - wenBefore, 0);
    doRead(12'h0A5, 8'h3C);
    doRead(12'hFFF, 8'hFF);

`ifdef SLAVE_PORT_PARITY_EN
    // Parity of 0x0A5 and 0x3C is even, so a 1 parity bit must be rejected.
    wenBefore = wenCount;
    applyStimulus(1'b1, 12'h0A5, 8'hC3, 1'b1);
    checkOutput("perrPulse", bus.perr, 1'b1);
    checkOutput("perrReady", bus.sready, 1'b1);
    checkOutput("perrNoWen", memWen, 1'b0);
    stepCycle();
    checkOutput("perrCleared", bus.perr, 1'b0);
    checkOutput("perrNoWenTotal", wenCount - wenBefore, 0);
    doRead(12'h0A5, 8'h3C);
    doWrite(12'h0A5, 8'hC3);
    doRead(12'h0A5, 8'hC3);
    checkOutput("perrTotal", perrCount, 1);
`else
    checkOutput("perrTotal", perrCount, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
